// File: rtl/stft_frame_sched_pkg.sv
// Shared types and default widths for the STFT frame scheduler.
package stft_sched_pkg;

  localparam int DEF_WL = 10;
  localparam int DEF_FW = 8;
  localparam int DEF_AW = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stft_frame_sched_if.sv
// Read-beat bus between the frame scheduler and the sample buffer.
// The scheduler drives addresses and window position tags; the buffer
// answers with ready.
interface stft_frame_sched_if
  import stft_sched_pkg::*;
#(
  parameter int WL = DEF_WL,
  parameter int FW = DEF_FW,
  parameter int AW = DEF_AW
);

  logic          iRD_RDY;
  logic          oRD_VLD;
  logic [AW-1:0] oRD_ADDR;
  logic [WL-1:0] oSMP_IDX;
  logic [FW-1:0] oFRM_IDX;
  logic          oWIN_FIRST;
  logic          oWIN_LAST;

  modport master (
    input  iRD_RDY,
    output oRD_VLD, oRD_ADDR, oSMP_IDX, oFRM_IDX, oWIN_FIRST, oWIN_LAST
  );

  modport slave (
    output iRD_RDY,
    input  oRD_VLD, oRD_ADDR, oSMP_IDX, oFRM_IDX, oWIN_FIRST, oWIN_LAST
  );

endinterface

// File: rtl/stft_frame_sched_mod_cnt.sv
// Enable-gated modulo counter 0..i_mod-1 with terminal-count flag.
module mod_cnt #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_mod,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == (i_mod - W'(1)));

  // Count up on enable, wrapping to zero after the terminal value; clear wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : (r_cnt + W'(1));
    end
  end

endmodule

// File: rtl/stft_frame_sched.sv
// STFT frame scheduler: walks F overlapping windows of N samples spaced by
// hop H through a circular sample buffer, one read beat per accepted cycle.
module stft_frame_sched
  import stft_sched_pkg::*;
#(
  parameter int WL = DEF_WL,
  parameter int FW = DEF_FW,
  parameter int AW = DEF_AW
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iABORT,
  input  logic [WL-1:0] iWIN_LEN,
  input  logic [WL-1:0] iHOP,
  input  logic [FW-1:0] iNUM_FRM,
  input  logic [AW-1:0] iBASE,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oERR,
  stft_frame_sched_if.master bus
);

  state_t        r_state;
  state_t        w_nextState;
  logic [WL-1:0] r_winLen;
  logic [WL-1:0] r_hop;
  logic [FW-1:0] r_numFrm;
  logic [AW-1:0] r_frmBase;
  logic [AW-1:0] r_rdAddr;
  logic [FW-1:0] r_frmIdx;
  logic          r_rdVld;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_cfgBad;
  logic          w_lastFrm;
  logic          w_smpClr;
  logic [WL-1:0] w_smpIdx;
  logic          w_smpTc;
  logic [AW-1:0] w_nextBase;

  // r_rdVld is only ever high in RUN, so it doubles as the RUN qualifier here.
  assign w_accept   = r_rdVld && bus.iRD_RDY;
  assign w_cfgBad   = (r_winLen < WL'(2)) || (r_hop == '0) ||
                      (r_hop > r_winLen) || (r_numFrm == '0);
  assign w_lastFrm  = (r_frmIdx == (r_numFrm - FW'(1)));
  assign w_nextBase = r_frmBase + AW'(r_hop);
  assign w_smpClr   = iABORT || (r_state != ST_RUN);

  mod_cnt #(.W(WL)) u_smpCnt (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_clr (w_smpClr),
    .i_en  (w_accept),
    .i_mod (r_winLen),
    .o_cnt (w_smpIdx),
    .o_tc  (w_smpTc)
  );

  assign bus.oRD_VLD    = r_rdVld;
  assign bus.oRD_ADDR   = r_rdAddr;
  assign bus.oSMP_IDX   = w_smpIdx;
  assign bus.oFRM_IDX   = r_frmIdx;
  assign bus.oWIN_FIRST = (r_state == ST_RUN) && (w_smpIdx == '0);
  assign bus.oWIN_LAST  = (r_state == ST_RUN) && w_smpTc;
  assign oBUSY          = r_busy;
  assign oDONE          = r_done;
  assign oERR           = r_err;

  // Next-state decode; abort beats acceptance, start only matters in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (iSTART) w_nextState = ST_CHECK;
      ST_CHECK: w_nextState = (iABORT || w_cfgBad) ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (iABORT) begin
          w_nextState = ST_IDLE;
        end else if (w_accept && w_smpTc && w_lastFrm) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Registered status outputs, config latch, frame counter and address walk.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_rdVld   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_winLen  <= '0;
      r_hop     <= '0;
      r_numFrm  <= '0;
      r_frmBase <= '0;
      r_rdAddr  <= '0;
      r_frmIdx  <= '0;
    end else begin
      r_rdVld <= (w_nextState == ST_RUN);
      r_busy  <= (w_nextState != ST_IDLE);
      r_done  <= (w_nextState == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (iSTART) begin
            r_winLen  <= iWIN_LEN;
            r_hop     <= iHOP;
            r_numFrm  <= iNUM_FRM;
            r_frmBase <= iBASE;
            r_rdAddr  <= iBASE;
            r_frmIdx  <= '0;
            r_err     <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!iABORT && w_cfgBad) r_err <= 1'b1;
        end
        ST_RUN: begin
          if (iABORT) begin
            r_frmIdx <= '0;
          end else if (w_accept) begin
            if (w_smpTc) begin
              r_frmBase <= w_nextBase;
              r_rdAddr  <= w_nextBase;
              r_frmIdx  <= w_lastFrm ? '0 : (r_frmIdx + FW'(1));
            end else begin
              r_rdAddr  <= r_rdAddr + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stft_frame_sched.sv
// Self-checking bench for stft_frame_sched, built with a 4-bit address so
// buffer wrap-around shows up in short jobs.
module tb_stft_frame_sched;

  localparam int TWL = 10;
  localparam int TFW = 8;
  localparam int TAW = 4;

  logic           iCLK = 1'b0;
  logic           iRST;
  logic           iSTART;
  logic           iABORT;
  logic [TWL-1:0] iWIN_LEN;
  logic [TWL-1:0] iHOP;
  logic [TFW-1:0] iNUM_FRM;
  logic [TAW-1:0] iBASE;
  logic           oBUSY;
  logic           oDONE;
  logic           oERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TAW-1:0] addr;
    int             smp;
    int             frm;
    logic           first;
    logic           last;
  } beat_t;

  beat_t sbQ[$];

  stft_frame_sched_if #(.WL(TWL), .FW(TFW), .AW(TAW)) bus();

  stft_frame_sched #(.WL(TWL), .FW(TFW), .AW(TAW)) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iSTART   (iSTART),
    .iABORT   (iABORT),
    .iWIN_LEN (iWIN_LEN),
    .iHOP     (iHOP),
    .iNUM_FRM (iNUM_FRM),
    .iBASE    (iBASE),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE),
    .oERR     (oERR),
    .bus      (bus)
  );

  // Free-running 10-unit clock.
  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a job; legal configs push every expected beat onto the scoreboard.
  // Returns at the falling edge of the CHECK cycle.
  task automatic applyStimulus(input int n, input int h, input int f, input int b);
    beat_t e;
    iWIN_LEN = TWL'(n);
    iHOP     = TWL'(h);
    iNUM_FRM = TFW'(f);
    iBASE    = TAW'(b);
    iSTART   = 1'b1;
    if (n >= 2 && h >= 1 && h <= n && f >= 1) begin
      for (int fi = 0; fi < f; fi++) begin
        for (int si = 0; si < n; si++) begin
          e.addr  = TAW'(b + fi * h + si);
          e.smp   = si;
          e.frm   = fi;
          e.first = (si == 0);
          e.last  = (si == n - 1);
          sbQ.push_back(e);
        end
      end
    end
    @(negedge iCLK);
    iSTART   = 1'b0;
    iWIN_LEN = '1;
    iHOP     = '1;
    iNUM_FRM = '1;
    iBASE    = '1;
    checkOutput("check_vld", 32'(bus.oRD_VLD), 32'd0);
    checkOutput("check_busy", 32'(oBUSY), 32'd1);
    checkOutput("check_err_clr", 32'(oERR), 32'd0);
  endtask

  // Consume the scoreboard beat by beat, optionally stalling or aborting,
  // then check the DONE pulse.
  task automatic drainJob(input int stallBeat, input int stallLen, input int abortBeat);
    int    accepted = 0;
    int    stalls   = 0;
    int    cycles   = 0;
    logic  rdy;
    beat_t e;
    @(negedge iCLK);
    while (sbQ.size() > 0 && cycles < 200) begin
      rdy = 1'b1;
      if (accepted + 1 == stallBeat && stalls < stallLen) begin
        rdy = 1'b0;
        stalls++;
      end
      bus.iRD_RDY = rdy;
      e = sbQ[0];
      checkOutput("beat_vld", 32'(bus.oRD_VLD), 32'd1);
      checkOutput("beat_done", 32'(oDONE), 32'd0);
      checkOutput("beat_addr", 32'(bus.oRD_ADDR), 32'(e.addr));
      checkOutput("beat_smp", 32'(bus.oSMP_IDX), 32'(e.smp));
      checkOutput("beat_frm", 32'(bus.oFRM_IDX), 32'(e.frm));
      checkOutput("beat_first", 32'(bus.oWIN_FIRST), 32'(e.first));
      checkOutput("beat_last", 32'(bus.oWIN_LAST), 32'(e.last));
      if (abortBeat != 0 && accepted + 1 == abortBeat) begin
        iABORT = 1'b1;
        @(negedge iCLK);
        iABORT = 1'b0;
        checkOutput("abort_vld", 32'(bus.oRD_VLD), 32'd0);
        checkOutput("abort_busy", 32'(oBUSY), 32'd0);
        checkOutput("abort_smp", 32'(bus.oSMP_IDX), 32'd0);
        checkOutput("abort_frm", 32'(bus.oFRM_IDX), 32'd0);
        for (int k = 0; k < 3; k++) begin
          checkOutput("abort_no_done", 32'(oDONE), 32'd0);
          @(negedge iCLK);
        end
        sbQ.delete();
        return;
      end
      if (rdy) begin
        void'(sbQ.pop_front());
        accepted++;
      end
      @(negedge iCLK);
      cycles++;
    end
    if (sbQ.size() > 0) begin
      checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    checkOutput("done_pulse", 32'(oDONE), 32'd1);
    checkOutput("done_vld", 32'(bus.oRD_VLD), 32'd0);
    @(negedge iCLK);
    checkOutput("done_clear", 32'(oDONE), 32'd0);
    checkOutput("idle_busy", 32'(oBUSY), 32'd0);
  endtask

  int badCfg [4][3] = '{'{4, 5, 3}, '{1, 1, 1}, '{4, 0, 2}, '{4, 2, 0}};

  initial begin
    iRST        = 1'b1;
    iSTART      = 1'b0;
    iABORT      = 1'b0;
    iWIN_LEN    = '0;
    iHOP        = '0;
    iNUM_FRM    = '0;
    iBASE       = '0;
    bus.iRD_RDY = 1'b0;
    repeat (2) @(negedge iCLK);
    checkOutput("rst_vld", 32'(bus.oRD_VLD), 32'd0);
    checkOutput("rst_busy", 32'(oBUSY), 32'd0);
    checkOutput("rst_done", 32'(oDONE), 32'd0);
    checkOutput("rst_err", 32'(oERR), 32'd0);
    checkOutput("rst_addr", 32'(bus.oRD_ADDR), 32'd0);
    checkOutput("rst_smp", 32'(bus.oSMP_IDX), 32'd0);
    checkOutput("rst_frm", 32'(bus.oFRM_IDX), 32'd0);
    checkOutput("rst_first", 32'(bus.oWIN_FIRST), 32'd0);
    checkOutput("rst_last", 32'(bus.oWIN_LAST), 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    $display("[TB] overlapping windows N=4 H=2 F=3");
    applyStimulus(4, 2, 3, 0);
    drainJob(0, 0, 0);

    $display("[TB] same job with ready stalled at beat 6");
    applyStimulus(4, 2, 3, 0);
    drainJob(6, 3, 0);

    $display("[TB] address wrap base 14");
    applyStimulus(4, 4, 2, 14);
    drainJob(0, 0, 0);

    $display("[TB] illegal configs");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(badCfg[i][0], badCfg[i][1], badCfg[i][2], 3);
      @(negedge iCLK);
      checkOutput("bad_err", 32'(oERR), 32'd1);
      checkOutput("bad_busy", 32'(oBUSY), 32'd0);
      checkOutput("bad_vld", 32'(bus.oRD_VLD), 32'd0);
      @(negedge iCLK);
      checkOutput("bad_err_sticky", 32'(oERR), 32'd1);
      checkOutput("bad_vld_idle", 32'(bus.oRD_VLD), 32'd0);
    end

    $display("[TB] legal job after error, H equal to N");
    applyStimulus(3, 3, 2, 5);
    drainJob(0, 0, 0);

    $display("[TB] abort at beat 5 then restart");
    applyStimulus(4, 2, 3, 0);
    drainJob(0, 0, 5);
    applyStimulus(4, 2, 3, 0);
    drainJob(0, 0, 0);

    $display("[TB] reset mid-run with start and abort");
    applyStimulus(5, 1, 2, 7);
    bus.iRD_RDY = 1'b1;
    repeat (3) @(negedge iCLK);
    iRST   = 1'b1;
    iSTART = 1'b1;
    iABORT = 1'b1;
    @(negedge iCLK);
    checkOutput("mrst_vld", 32'(bus.oRD_VLD), 32'd0);
    checkOutput("mrst_busy", 32'(oBUSY), 32'd0);
    checkOutput("mrst_done", 32'(oDONE), 32'd0);
    checkOutput("mrst_err", 32'(oERR), 32'd0);
    checkOutput("mrst_addr", 32'(bus.oRD_ADDR), 32'd0);
    checkOutput("mrst_smp", 32'(bus.oSMP_IDX), 32'd0);
    checkOutput("mrst_frm", 32'(bus.oFRM_IDX), 32'd0);
    checkOutput("mrst_first", 32'(bus.oWIN_FIRST), 32'd0);
    iRST   = 1'b0;
    iSTART = 1'b0;
    iABORT = 1'b0;
    sbQ.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge iCLK);
      checkOutput("mrst_idle_busy", 32'(oBUSY), 32'd0);
      checkOutput("mrst_idle_done", 32'(oDONE), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
